dcache_2way_ctrl: RTL and testbench
===================================

// Module: dcache_2way_ctrl
// PURPOSE
// - Sequencing FSM for the 2-way set-associative data cache between the pipeline MEM stage and data memory.
// - Consumes tag-SRAM lookup results and the way-hit decision; stalls the CPU on a miss.
// - On a miss, picks a victim (invalid first, else LRU), writes it back if dirty, refills the line, then replays the access.
// - Owns per-set LRU state and all tag/data SRAM write strobes.
// PARAMETERS
// - SETS    16  number of sets; index width = $clog2(SETS)
// - TAG_W   23  address tag width; tag word = {valid, dirty, tag[TAG_W-1:0]} = TAG_W+2 bits
// - OFF_W    5  byte-offset width (32-byte line)
// PORTS
// - clk_i          in   1   clock
// - rst_i          in   1   asynchronous reset, active-low
// - cpu_req_i      in   1   MEM-stage access valid
// - cpu_we_i       in   1   1 = store, 0 = load
// - cpu_addr_i     in   32  byte address {tag, index, offset}
// - cpu_stall_o    out  1   hold pipeline; access not yet complete
// - tag0_i         in   25  way-0 tag word at current index; [24]=valid, [23]=dirty, [22:0]=tag
// - tag1_i         in   25  way-1 tag word at current index
// - hit_way_i      in   2   comparator result: 00 = way0, 01 = way1, 10 = miss
// - sram_we_o      out  1   write strobe for tag+data SRAM of way sram_way_o
// - sram_way_o     out  1   way being written or read for writeback
// - sram_tag_o     out  25  tag word to write
// - sram_fill_o    out  1   1 = data from mem_rdata path (refill); 0 = CPU store merge
// - mem_req_o      out  1   memory request, held until mem_ack_i
// - mem_we_o       out  1   1 = writeback line, 0 = line fetch
// - mem_addr_o     out  32  line address, low OFF_W bits = 0
// - mem_ack_i      in   1   one-cycle completion pulse from memory
// BEHAVIOUR
// - Reset (rst_i low, async): state IDLE, all LRU bits 0, all outputs 0. Reset mid-miss aborts immediately; mem_req_o drops the same instant.
// - States: IDLE, WB (writeback), FILL (fetch), REFILL (SRAM write), then back to IDLE to replay.
// - IDLE, cpu_req_i=0: all outputs 0, no state change.
// - IDLE hit: cpu_stall_o=0 (zero-cycle hit). Store hit: sram_we_o=1, sram_fill_o=0, sram_way_o=hit way, sram_tag_o={1,1,tag}. LRU[index] <= other way.
// - IDLE miss: cpu_stall_o=1 combinationally. Victim: way0 if !tag0_i[24]; else way1 if !tag1_i[24]; else LRU[index]. Victim registered.
//   Dirty victim (valid & dirty) -> WB, else -> FILL.
// - WB: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 0}, sram_way_o=victim. On mem_ack_i -> FILL.
// - FILL: mem_req_o=1, mem_we_o=0, mem_addr_o={cpu tag, index, 0}. On mem_ack_i -> REFILL.
// - REFILL (exactly 1 cycle): sram_we_o=1, sram_fill_o=1, sram_way_o=victim, sram_tag_o={1,0,cpu tag}; LRU[index] <= other way; -> IDLE.
// - Replay in IDLE hits the refilled way; a store then sets dirty via the store-hit path.
// - cpu_stall_o=1 in every non-IDLE state.
// - mem_req_o never deasserts before mem_ack_i except on reset. mem_ack_i outside WB/FILL is ignored.
// - cpu_addr_i/cpu_we_i must stay stable while stalled. cpu_req_i dropping mid-miss does not abort: fill completes, replay suppressed.
// - Miss latency = 1 + mem latency (fill) [+ mem latency (writeback)] + 1 replay cycle.
// STRUCTURE
// - Shared package: state enum, tag-word field positions (VALID_BIT=24, DIRTY_BIT=23), hit_way encodings (WAY0=2'b00, WAY1=2'b01, MISS=2'b10).
// - Single module; LRU is a SETS-bit register array inside it. No sub-module required.
// TESTING
// - Reset then load to 0x0000_0040, both ways invalid -> FILL to 0x40, REFILL way0 tag {1,0,0}, LRU[2]=1, stall released after replay.
// - Store hit way1, index 3 -> same-cycle stall=0, sram_we_o=1, sram_tag_o dirty=1, LRU[3]=0.
// - Miss, both ways valid, LRU=1, way1 dirty -> WB to {tag1,index,0} precedes FILL; mem_we_o 1 then 0.
// - Clean-victim miss with 5-cycle mem_ack_i -> no WB; stall high exactly 5+2 cycles.
// - Assert rst_i low during WB -> mem_req_o drops at once; IDLE, LRU cleared; late mem_ack_i ignored.
// - cpu_req_i drops during FILL -> REFILL still writes; no replay; next IDLE outputs all 0.

Source files
------------

// File: rtl/dcache_2way_ctrl_pkg.sv
// Shared definitions for the 2-way data-cache sequencer.
// - state_e      : controller states (IDLE, WB, FILL, REFILL)
// - VALID_BIT /
//   DIRTY_BIT    : field positions inside the 25-bit tag word {valid, dirty, tag[22:0]}
// - WAY0/WAY1/MISS : encodings of the tag comparator's hit_way result
// - pick_victim  : replacement choice (an invalid way first, otherwise the LRU way)
package dcache_2way_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_FILL   = 2'd2,
    ST_REFILL = 2'd3
  } state_e;

  localparam int VALID_BIT = 24;
  localparam int DIRTY_BIT = 23;

  localparam logic [1:0] WAY0 = 2'b00;
  localparam logic [1:0] WAY1 = 2'b01;
  localparam logic [1:0] MISS = 2'b10;

  // Fill an empty way before evicting anything; only fall back to LRU when both are valid.
  function automatic logic pick_victim(input logic v0, input logic v1, input logic lru);
    if (!v0)      return 1'b0;
    else if (!v1) return 1'b1;
    else          return lru;
  endfunction

endpackage

// File: rtl/dcache_2way_ctrl.sv
// Miss-handling sequencer for a 2-way set-associative data cache sitting
// between the MEM stage and data memory.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   cpu_req_i/we_i/addr_i  MEM-stage access (addr = {tag, index, offset})
//   cpu_stall_o         hold the pipeline until the access completes
//   tag0_i, tag1_i      tag words of both ways at the current index
//   hit_way_i           comparator result (WAY0, WAY1, MISS)
//   sram_we_o/way_o/tag_o/fill_o  tag+data SRAM write port control
//   mem_req_o/we_o/addr_o, mem_ack_i  line-granular memory handshake
// Hits complete in the same cycle. A miss picks a victim, writes it back
// when dirty, fetches the line, writes it into the SRAM, then returns to
// IDLE where the still-presented access replays as a hit.
module dcache_2way_ctrl
  import dcache_2way_ctrl_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int TAG_W = 23,
  parameter int OFF_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [31:0]      cpu_addr_i,
  output logic             cpu_stall_o,
  input  logic [TAG_W+1:0] tag0_i,
  input  logic [TAG_W+1:0] tag1_i,
  input  logic [1:0]       hit_way_i,
  output logic             sram_we_o,
  output logic             sram_way_o,
  output logic [TAG_W+1:0] sram_tag_o,
  output logic             sram_fill_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  input  logic             mem_ack_i
);

  localparam int IDX_W = $clog2(SETS);

  state_e            state_q;
  logic              victim_q;
  logic [SETS-1:0]   lru_q;       // per set: the way to evict next
  logic              mem_req_q;
  logic              mem_we_q;
  logic [31:0]       mem_addr_q;

  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  cpu_idx;
  logic              is_hit;
  logic              hit_way;
  logic              victim_sel;
  logic [TAG_W+1:0]  vic_word;
  logic              vic_dirty;
  logic              addr_off_unused;

  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i);
    return {t, i, {OFF_W{1'b0}}};
  endfunction

  assign cpu_tag         = cpu_addr_i[31 -: TAG_W];
  assign cpu_idx         = cpu_addr_i[OFF_W +: IDX_W];
  assign addr_off_unused = ^cpu_addr_i[OFF_W-1:0];

  // Any encoding other than WAY0/WAY1 is treated as a miss.
  assign is_hit     = (hit_way_i == WAY0) || (hit_way_i == WAY1);
  assign hit_way    = hit_way_i[0];
  assign victim_sel = pick_victim(tag0_i[VALID_BIT], tag1_i[VALID_BIT], lru_q[cpu_idx]);
  assign vic_word   = victim_sel ? tag1_i : tag0_i;
  assign vic_dirty  = vic_word[VALID_BIT] & vic_word[DIRTY_BIT];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      victim_q   <= 1'b0;
      lru_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_req_i) begin
            if (is_hit) begin
              lru_q[cpu_idx] <= ~hit_way;
            end else begin
              // Victim and writeback address are captured here so the later
              // states do not depend on the tag SRAM outputs.
              victim_q  <= victim_sel;
              mem_req_q <= 1'b1;
              if (vic_dirty) begin
                state_q    <= ST_WB;
                mem_we_q   <= 1'b1;
                mem_addr_q <= line_addr(vic_word[TAG_W-1:0], cpu_idx);
              end else begin
                state_q    <= ST_FILL;
                mem_we_q   <= 1'b0;
                mem_addr_q <= line_addr(cpu_tag, cpu_idx);
              end
            end
          end
        end
        ST_WB: begin
          // The request stays up across WB -> FILL; only the direction and address change.
          if (mem_ack_i) begin
            state_q    <= ST_FILL;
            mem_we_q   <= 1'b0;
            mem_addr_q <= line_addr(cpu_tag, cpu_idx);
          end
        end
        ST_FILL: begin
          if (mem_ack_i) begin
            state_q    <= ST_REFILL;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
          end
        end
        ST_REFILL: begin
          lru_q[cpu_idx] <= ~victim_q;
          state_q        <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // SRAM strobes and stall must react in the hit cycle, so they decode state and inputs directly.
  always_comb begin
    cpu_stall_o = 1'b0;
    sram_we_o   = 1'b0;
    sram_way_o  = 1'b0;
    sram_tag_o  = '0;
    sram_fill_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i) begin
          cpu_stall_o = !is_hit;
          if (is_hit && cpu_we_i) begin
            sram_we_o  = 1'b1;
            sram_way_o = hit_way;
            sram_tag_o = {1'b1, 1'b1, cpu_tag};
          end
        end
      end
      ST_WB: begin
        cpu_stall_o = 1'b1;
        sram_way_o  = victim_q;
      end
      ST_FILL: begin
        cpu_stall_o = 1'b1;
      end
      ST_REFILL: begin
        cpu_stall_o = 1'b1;
        sram_we_o   = 1'b1;
        sram_fill_o = 1'b1;
        sram_way_o  = victim_q;
        sram_tag_o  = {1'b1, 1'b0, cpu_tag};
      end
      default: ;
    endcase
  end

  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_dcache_2way_ctrl.sv
module tb_dcache_2way_ctrl;

  localparam int SETS  = 16;
  localparam int TAG_W = 23;
  localparam int OFF_W = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr;
  logic        cpu_stall_o;
  logic [24:0] tag0, tag1;
  logic [1:0]  hit_way;
  logic        sram_we_o, sram_way_o, sram_fill_o;
  logic [24:0] sram_tag_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack;

  always #5 clk = ~clk;

  dcache_2way_ctrl #(.SETS(SETS), .TAG_W(TAG_W), .OFF_W(OFF_W)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_stall_o(cpu_stall_o),
    .tag0_i(tag0), .tag1_i(tag1), .hit_way_i(hit_way),
    .sram_we_o(sram_we_o), .sram_way_o(sram_way_o), .sram_tag_o(sram_tag_o), .sram_fill_o(sram_fill_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack)
  );

  int total = 0;
  int bad   = 0;

  // Cache contents as the bench believes them to be (also what the "tag SRAM" presents).
  logic        m_valid [SETS][2];
  logic        m_dirty [SETS][2];
  logic [22:0] m_tag   [SETS][2];
  logic        m_lru   [SETS];

  // Expected outputs for the current cycle plus which fields are defined this cycle.
  logic        exp_en = 1'b0;
  logic        e_stall, e_swe, e_sway, e_sfill, e_mreq, e_mwe;
  logic [24:0] e_stag;
  logic [31:0] e_maddr;
  logic        c_way, c_tag, c_fill, c_mem;

  // Observations of the DUT for the literal checks.
  int          stall_cnt = 0;
  logic [31:0] seen_wb_addr = '0, seen_fill_addr = '0;
  logic [24:0] seen_refill_tag = '0, seen_store_tag = '0;
  logic        we_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_en) begin
      chk("stall", {31'h0, cpu_stall_o}, {31'h0, e_stall});
      chk("sram_we", {31'h0, sram_we_o}, {31'h0, e_swe});
      chk("mem_req", {31'h0, mem_req_o}, {31'h0, e_mreq});
      if (c_way)  chk("sram_way", {31'h0, sram_way_o}, {31'h0, e_sway});
      if (c_tag)  chk("sram_tag", {7'h0, sram_tag_o}, {7'h0, e_stag});
      if (c_fill) chk("sram_fill", {31'h0, sram_fill_o}, {31'h0, e_sfill});
      if (c_mem) begin
        chk("mem_we", {31'h0, mem_we_o}, {31'h0, e_mwe});
        chk("mem_addr", mem_addr_o, e_maddr);
      end
    end
  end

  always @(negedge clk) begin
    if (cpu_stall_o === 1'b1) stall_cnt++;
    if (mem_req_o === 1'b1) begin
      we_q.push_back(mem_we_o);
      if (mem_we_o) seen_wb_addr = mem_addr_o;
      else          seen_fill_addr = mem_addr_o;
    end
    if (sram_we_o === 1'b1) begin
      if (sram_fill_o) seen_refill_tag = sram_tag_o;
      else             seen_store_tag  = sram_tag_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic st, input logic swe, input logic sway, input logic [24:0] stag,
                            input logic sfill, input logic mreq, input logic mwe, input logic [31:0] maddr,
                            input logic cw, input logic ct, input logic cf, input logic cm);
    e_stall = st; e_swe = swe; e_sway = sway; e_stag = stag; e_sfill = sfill;
    e_mreq = mreq; e_mwe = mwe; e_maddr = maddr;
    c_way = cw; c_tag = ct; c_fill = cf; c_mem = cm;
    exp_en = 1'b1;
  endtask

  // No access in flight: every output is zero.
  task automatic expect_idle();
    expect_out(1'b0, 1'b0, 1'b0, 25'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic idle(input int n, input logic ack);
    for (int k = 0; k < n; k++) begin
      cpu_req = 1'b0; cpu_we = 1'b0; mem_ack = ack;
      expect_idle();
      step();
    end
    mem_ack = 1'b0;
  endtask

  // Tag SRAM + comparator as seen from the bench's cache model.
  task automatic present(input logic [31:0] a);
    logic [3:0]  idx;
    logic [22:0] t;
    idx = a[8:5];
    t   = a[31:9];
    cpu_addr = a;
    tag0 = {m_valid[idx][0], m_dirty[idx][0], m_tag[idx][0]};
    tag1 = {m_valid[idx][1], m_dirty[idx][1], m_tag[idx][1]};
    if (m_valid[idx][0] && m_tag[idx][0] == t)      hit_way = 2'b00;
    else if (m_valid[idx][1] && m_tag[idx][1] == t) hit_way = 2'b01;
    else                                            hit_way = 2'b10;
  endtask

  // One CPU access, cycle by cycle. wb_lat/fill_lat are the number of cycles the
  // memory holds off before its ack pulse; drop lowers cpu_req in the first FILL cycle;
  // abort_k >= 0 pulls reset in that writeback cycle.
  task automatic access(input logic [31:0] a, input logic we, input int wb_lat, input int fill_lat,
                        input bit drop, input int abort_k, input bit replay);
    logic [3:0]  idx;
    logic [22:0] t, vt;
    logic        w, vic, vd;
    idx = a[8:5];
    t   = a[31:9];
    cpu_req = 1'b1; cpu_we = we; mem_ack = 1'b0;
    present(a);
    if (hit_way != 2'b10) begin
      w = hit_way[0];
      if (we) expect_out(1'b0, 1'b1, w, {2'b11, t}, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      else    expect_out(1'b0, 1'b0, 1'b0, 25'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      m_lru[idx] = ~w;
      if (we) m_dirty[idx][w] = 1'b1;
      step();
      return;
    end
    if (replay) begin
      total++; bad++;
      $display("FAIL replay_hit: access %0h still misses after refill", a);
      return;
    end
    if (!m_valid[idx][0])      vic = 1'b0;
    else if (!m_valid[idx][1]) vic = 1'b1;
    else                       vic = m_lru[idx];
    vd = m_valid[idx][vic] && m_dirty[idx][vic];
    vt = m_tag[idx][vic];
    expect_out(1'b1, 1'b0, 1'b0, 25'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    if (vd) begin
      for (int k = 0; k < wb_lat; k++) begin
        mem_ack = (k == wb_lat - 1);
        expect_out(1'b1, 1'b0, vic, 25'h0, 1'b0, 1'b1, 1'b1, {vt, idx, 5'b0}, 1'b1, 1'b0, 1'b0, 1'b1);
        if (k == abort_k) begin
          #2;
          rst_n = 1'b0; cpu_req = 1'b0; mem_ack = 1'b0; exp_en = 1'b0;
          #1;
          chk("abort_mem_req", {31'h0, mem_req_o}, 32'h0);
          chk("abort_stall", {31'h0, cpu_stall_o}, 32'h0);
          chk("abort_sram_we", {31'h0, sram_we_o}, 32'h0);
          for (int s = 0; s < SETS; s++) m_lru[s] = 1'b0;
          return;
        end
        step();
      end
    end
    for (int k = 0; k < fill_lat; k++) begin
      mem_ack = (k == fill_lat - 1);
      if (drop && k == 0) cpu_req = 1'b0;
      expect_out(1'b1, 1'b0, 1'b0, 25'h0, 1'b0, 1'b1, 1'b0, {t, idx, 5'b0}, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    mem_ack = 1'b0;
    expect_out(1'b1, 1'b1, vic, {2'b10, t}, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    m_valid[idx][vic] = 1'b1;
    m_dirty[idx][vic] = 1'b0;
    m_tag[idx][vic]   = t;
    m_lru[idx]        = ~vic;
    step();
    if (drop) idle(1, 1'b0);
    else      access(a, we, 0, 0, 1'b0, -1, 1'b1);
  endtask

  initial begin
    for (int s = 0; s < SETS; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0; m_tag[s][w] = '0;
      end
    end
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    tag0 = '0; tag1 = '0; hit_way = 2'b10; mem_ack = 1'b0;
    #12;
    chk("reset_stall", {31'h0, cpu_stall_o}, 32'h0);
    chk("reset_mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("reset_sram_we", {31'h0, sram_we_o}, 32'h0);
    chk("reset_mem_addr", mem_addr_o, 32'h0);
    step();
    rst_n = 1'b1;
    idle(2, 1'b0);

    // Cold miss to 0x40: fill into way0, replay as hit.
    access(32'h0000_0040, 1'b0, 0, 2, 1'b0, -1, 1'b0);
    chk("t1_fill_addr", seen_fill_addr, 32'h0000_0040);
    chk("t1_refill_tag", {7'h0, seen_refill_tag}, 32'h0100_0000);
    chk("t1_model_lru2", {31'h0, m_lru[2]}, 32'h1);
    idle(1, 1'b0);

    // Set 3: A into way0, B into way1, then a store hit on way1.
    access(32'h0000_0260, 1'b0, 0, 1, 1'b0, -1, 1'b0);
    access(32'h0000_0460, 1'b0, 0, 1, 1'b0, -1, 1'b0);
    access(32'h0000_0464, 1'b1, 0, 0, 1'b0, -1, 1'b0);
    chk("t2_store_tag", {7'h0, seen_store_tag}, 32'h0180_0002);
    chk("t2_model_lru3", {31'h0, m_lru[3]}, 32'h0);

    // Load A (LRU -> way1), then miss C: dirty way1 (B) written back before the fill.
    access(32'h0000_0260, 1'b0, 0, 0, 1'b0, -1, 1'b0);
    we_q.delete();
    access(32'h0000_0660, 1'b0, 2, 2, 1'b0, -1, 1'b0);
    chk("t3_wb_addr", seen_wb_addr, 32'h0000_0460);
    chk("t3_fill_addr", seen_fill_addr, 32'h0000_0660);
    chk("t3_first_we", {31'h0, we_q[0]}, 32'h1);
    chk("t3_last_we", {31'h0, we_q[$]}, 32'h0);
    idle(1, 1'b1);

    // Clean-victim miss with a 5-cycle memory: stall for 1 + 5 + 1 cycles.
    stall_cnt = 0;
    access(32'h0000_0A40, 1'b0, 0, 5, 1'b0, -1, 1'b0);
    chk("t4_stall_cycles", stall_cnt, 32'd7);

    // Dirty both ways of set 3 (LRU ends at way1), miss D, reset during writeback.
    access(32'h0000_0660, 1'b1, 0, 0, 1'b0, -1, 1'b0);
    access(32'h0000_0260, 1'b1, 0, 0, 1'b0, -1, 1'b0);
    access(32'h0000_0860, 1'b0, 4, 2, 1'b0, 1, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    idle(1, 1'b1);
    idle(2, 1'b0);
    // LRU was cleared, so the same miss now evicts way0 (A) instead of way1 (C).
    access(32'h0000_0860, 1'b0, 1, 3, 1'b0, -1, 1'b0);
    chk("t5_wb_addr_after_reset", seen_wb_addr, 32'h0000_0260);

    // cpu_req drops during FILL: the refill still happens, no replay.
    access(32'h0000_0EE0, 1'b0, 0, 3, 1'b1, -1, 1'b0);
    chk("t6_refill_tag", {7'h0, seen_refill_tag}, 32'h0100_0007);
    idle(1, 1'b0);
    access(32'h0000_0EE0, 1'b0, 0, 0, 1'b0, -1, 1'b0);
    idle(2, 1'b0);

    exp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
